// File: rtl/blit_pkg.sv
// rtl/blit_pkg.sv - shared types and constants for the blit logic-function sequencer
package blit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_SRC,
        ST_RD_DST,
        ST_WR_DST,
        ST_NEXT,
        ST_FIN
    } blit_state_t;

    localparam logic [3:0] LFU_ZERO = 4'b0000;
    localparam logic [3:0] LFU_SRC  = 4'b1100;
    localparam logic [3:0] LFU_XOR  = 4'b0110;
    localparam logic [3:0] LFU_ONE  = 4'b1111;

    localparam int LEN_W = 16;

    // Function result ignores dst when both dst polarities select the same bit.
    function automatic logic lfu_dst_indep(input logic [3:0] f);
        return (f[3] == f[2]) && (f[1] == f[0]);
    endfunction

endpackage

// File: rtl/lfu_word.sv
// rtl/lfu_word.sv - per-bit 4:1 logic function select over a data word
module lfu_word #(
    parameter int DW = 8
) (
    input  logic [3:0]    lfuc,
    input  logic [DW-1:0] src,
    input  logic [DW-1:0] dst,
    output logic [DW-1:0] result
);

    for (genvar i = 0; i < DW; i++) begin : g_bit
        assign result[i] = lfuc[{src[i], dst[i]}];
    end

endmodule

// File: rtl/blit_lfu_seq.sv
// rtl/blit_lfu_seq.sv - read-modify-write blit sequencer applying a 4-bit logic function
module blit_lfu_seq
    import blit_pkg::*;
#(
    parameter int AW = 20,
    parameter int DW = 8
) (
    input  logic             MasterClock,
    input  logic             RESETL,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [AW-1:0]    CMD_SRC,
    input  logic [AW-1:0]    CMD_DST,
    input  logic [LEN_W-1:0] CMD_LEN,
    input  logic [3:0]       CMD_LFUC,
    output logic             MEM_REQ,
    output logic             MEM_WR,
    output logic [AW-1:0]    MEM_ADDR,
    output logic [DW-1:0]    MEM_WDATA,
    input  logic             MEM_ACK,
    input  logic [DW-1:0]    MEM_RDATA,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [AW-1:0]    ADDR_ONE = 1;
    localparam logic [LEN_W-1:0] LEN_ONE  = 1;

    blit_state_t      state, state_next;
    logic [AW-1:0]    src_ptr, dst_ptr;
    logic [LEN_W-1:0] remaining;
    logic [3:0]       lfuc;
    logic [DW-1:0]    sreg, dreg, result;
    logic             accept, acc_done, mem_state, issue, req_next;

    lfu_word #(.DW(DW)) u_lfu (
        .lfuc   (lfuc),
        .src    (sreg),
        .dst    (dreg),
        .result (result)
    );

    always_comb begin
        state_next = state;
        CMD_READY  = (state == ST_IDLE) && !DONE;
        accept     = CMD_VALID && CMD_READY;
        acc_done   = MEM_REQ && MEM_ACK;
        mem_state  = (state == ST_RD_SRC) || (state == ST_RD_DST) || (state == ST_WR_DST);
        // The request register rises one cycle into each memory state, leaving a gap after every ACK.
        issue      = mem_state && !MEM_REQ;
        req_next   = mem_state && !acc_done;
        case (state)
            ST_IDLE:   if (accept) state_next = (CMD_LEN == '0) ? ST_FIN : ST_RD_SRC;
            ST_RD_SRC: if (acc_done) state_next = lfu_dst_indep(lfuc) ? ST_WR_DST : ST_RD_DST;
            ST_RD_DST: if (acc_done) state_next = ST_WR_DST;
            ST_WR_DST: if (acc_done) state_next = ST_NEXT;
            ST_NEXT:   state_next = (remaining == LEN_ONE) ? ST_FIN : ST_RD_SRC;
            ST_FIN:    state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign BUSY = (state != ST_IDLE) || DONE;

    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            state     <= ST_IDLE;
            MEM_REQ   <= 1'b0;
            MEM_WR    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            DONE      <= 1'b0;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            lfuc      <= '0;
            sreg      <= '0;
            dreg      <= '0;
        end else begin
            state   <= state_next;
            MEM_REQ <= req_next;
            DONE    <= (state == ST_FIN);
            if (issue) begin
                MEM_WR    <= (state == ST_WR_DST);
                MEM_ADDR  <= (state == ST_RD_SRC) ? src_ptr : dst_ptr;
                MEM_WDATA <= (state == ST_WR_DST) ? result : '0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        src_ptr   <= CMD_SRC;
                        dst_ptr   <= CMD_DST;
                        remaining <= CMD_LEN;
                        lfuc      <= CMD_LFUC;
                    end
                end
                ST_RD_SRC: begin
                    if (acc_done) begin
                        sreg <= MEM_RDATA;
                        if (lfu_dst_indep(lfuc)) dreg <= '0;
                    end
                end
                ST_RD_DST: if (acc_done) dreg <= MEM_RDATA;
                ST_NEXT: begin
                    src_ptr   <= src_ptr + ADDR_ONE;
                    dst_ptr   <= dst_ptr + ADDR_ONE;
                    remaining <= remaining - LEN_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_blit_lfu_seq.sv
// tb/tb_blit_lfu_seq.sv - self-checking bench for blit_lfu_seq with memory responder and op scoreboard
module tb_blit_lfu_seq;
    import blit_pkg::*;

    localparam int AW = 20;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          CMD_VALID, CMD_READY;
    logic [AW-1:0] CMD_SRC, CMD_DST;
    logic [15:0]   CMD_LEN;
    logic [3:0]    CMD_LFUC;
    logic          MEM_REQ, MEM_WR, MEM_ACK;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA, MEM_RDATA;
    logic          BUSY, DONE;

    always #5 clk = ~clk;

    blit_lfu_seq #(.AW(AW), .DW(DW)) dut (
        .MasterClock (clk),
        .RESETL      (rst_n),
        .CMD_VALID   (CMD_VALID),
        .CMD_READY   (CMD_READY),
        .CMD_SRC     (CMD_SRC),
        .CMD_DST     (CMD_DST),
        .CMD_LEN     (CMD_LEN),
        .CMD_LFUC    (CMD_LFUC),
        .MEM_REQ     (MEM_REQ),
        .MEM_WR      (MEM_WR),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_WDATA   (MEM_WDATA),
        .MEM_ACK     (MEM_ACK),
        .MEM_RDATA   (MEM_RDATA),
        .BUSY        (BUSY),
        .DONE        (DONE)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    typedef struct {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [15:0]   len;
        logic [3:0]    lfuc;
        int            dly;
        logic [31:0]   sdat;
        logic [31:0]   ddat;
    } vec_t;

    op_t           sbq[$];
    vec_t          vt[7];
    logic [DW-1:0] mem[logic [AW-1:0]];
    int            n_pass = 0;
    int            n_tot = 0;
    int            cyc = 0;
    int            ack_delay = 0;
    int            wait_cnt = 0;
    int            first_req_cyc = -1;
    int            wr_cnt = 0;
    logic [AW-1:0] cap_addr;
    logic          cap_wr;
    logic [DW-1:0] cap_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic logic [7:0] lfu_model(input logic [3:0] f, input logic [7:0] s, input logic [7:0] d);
        return ({8{f[3]}} & s & d) | ({8{f[2]}} & s & ~d) | ({8{f[1]}} & ~s & d) | ({8{f[0]}} & ~s & ~d);
    endfunction

    function automatic logic skips_dst(input logic [3:0] f);
        return (f == 4'b0000) || (f == 4'b0011) || (f == 4'b1100) || (f == 4'b1111);
    endfunction

    // Memory responder: ACKs after ack_delay wait cycles and scores every completed access.
    initial begin
        op_t e;
        MEM_ACK   = 1'b0;
        MEM_RDATA = '0;
        forever begin
            @(posedge clk);
            #1;
            MEM_ACK = 1'b0;
            if (MEM_REQ) begin
                if (first_req_cyc < 0) first_req_cyc = cyc;
                if (wait_cnt == 0) begin
                    cap_addr = MEM_ADDR; cap_wr = MEM_WR; cap_wdata = MEM_WDATA;
                end else begin
                    chk("hold_addr", 32'(MEM_ADDR), 32'(cap_addr));
                    chk("hold_wr", 32'(MEM_WR), 32'(cap_wr));
                    chk("hold_wdata", 32'(MEM_WDATA), 32'(cap_wdata));
                end
                if (wait_cnt >= ack_delay) begin
                    MEM_ACK  = 1'b1;
                    wait_cnt = 0;
                    if (MEM_WR) begin
                        mem[MEM_ADDR] = MEM_WDATA;
                        wr_cnt++;
                    end else begin
                        MEM_RDATA = mem.exists(MEM_ADDR) ? mem[MEM_ADDR] : 8'h00;
                    end
                    if (sbq.size() == 0) begin
                        chk("sb_unexpected_req", 32'd1, 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("sb_wr", 32'(MEM_WR), 32'(e.wr));
                        chk("sb_addr", 32'(MEM_ADDR), 32'(e.addr));
                        if (e.wr) chk("sb_wdata", 32'(MEM_WDATA), 32'(e.data));
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic load_vec(input vec_t v);
        logic [AW-1:0] sa, da;
        logic [7:0]    s, d;
        ack_delay = v.dly;
        for (int i = 0; i < int'(v.len); i++) begin
            sa = v.src + AW'(i);
            da = v.dst + AW'(i);
            s  = v.sdat[8*i +: 8];
            d  = v.ddat[8*i +: 8];
            mem[sa] = s;
            mem[da] = d;
            sbq.push_back('{1'b0, sa, 8'h00});
            if (!skips_dst(v.lfuc)) sbq.push_back('{1'b0, da, 8'h00});
            sbq.push_back('{1'b1, da, lfu_model(v.lfuc, s, d)});
        end
    endtask

    task automatic start_cmd(input vec_t v, output int acc);
        for (int k = 0; k < 100 && !CMD_READY; k++) begin
            @(posedge clk);
            #1;
        end
        if (!CMD_READY) chk("cmd_ready_wait", 32'd0, 32'd1);
        first_req_cyc = -1;
        CMD_SRC   = v.src;
        CMD_DST   = v.dst;
        CMD_LEN   = v.len;
        CMD_LFUC  = v.lfuc;
        CMD_VALID = 1'b1;
        acc = cyc;
        @(posedge clk);
        #1;
        CMD_VALID = 1'b0;
        CMD_SRC   = AW'($urandom);
        CMD_DST   = AW'($urandom);
        CMD_LEN   = 16'($urandom);
        CMD_LFUC  = 4'($urandom);
    endtask

    task automatic run_vec(input vec_t v);
        int   acc, per;
        int   dn = -1;
        logic busy_ok = 1'b1;
        load_vec(v);
        start_cmd(v, acc);
        for (int k = 0; k < 2000; k++) begin
            if (DONE) begin
                dn = cyc;
                break;
            end
            if (!BUSY) busy_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("done_seen", 32'(dn >= 0), 32'd1);
        chk("busy_hold", 32'(busy_ok), 32'd1);
        chk("busy_at_done", 32'(BUSY), 32'd1);
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(DONE), 32'd0);
        chk("busy_after", 32'(BUSY), 32'd0);
        chk("ready_after", 32'(CMD_READY), 32'd1);
        if (v.len == 16'd0) begin
            chk("null_latency", 32'(dn - acc), 32'd2);
            chk("null_no_req", 32'(first_req_cyc), 32'hFFFF_FFFF);
        end else begin
            per = (skips_dst(v.lfuc) ? 2 : 3) * (2 + v.dly) + 1;
            chk("latency", 32'(dn - first_req_cyc), 32'(int'(v.len) * per));
        end
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t rv;
        int   acc;
        CMD_VALID = 1'b0;
        CMD_SRC   = '0;
        CMD_DST   = '0;
        CMD_LEN   = '0;
        CMD_LFUC  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(CMD_READY), 32'd1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_req", 32'(MEM_REQ), 32'd0);
        chk("rst_wr", 32'(MEM_WR), 32'd0);
        chk("rst_addr", 32'(MEM_ADDR), 32'd0);
        chk("rst_wdata", 32'(MEM_WDATA), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        vt[0] = '{20'h00100, 20'h00200, 16'd1, LFU_XOR,  0, 32'h0000_00A5, 32'h0000_000F};
        vt[1] = '{20'h00010, 20'h00040, 16'd3, LFU_SRC,  0, 32'h0033_2211, 32'h0099_9999};
        vt[2] = '{20'h00300, 20'h00310, 16'd0, LFU_XOR,  0, 32'h0000_0000, 32'h0000_0000};
        vt[3] = '{20'h00500, 20'hFFFFF, 16'd2, LFU_ONE,  0, 32'h0000_3412, 32'h0000_7700};
        vt[4] = '{20'h00600, 20'h00700, 16'd2, LFU_XOR,  3, 32'h0000_F03C, 32'h0000_0F55};
        vt[5] = '{20'h00800, 20'h00900, 16'd3, 4'b1000,  1, 32'h00FF_AAF0, 32'h0001_55CC};
        vt[6] = '{20'h00A00, 20'h00B00, 16'd1, LFU_ZERO, 0, 32'h0000_00FF, 32'h0000_00FF};
        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        chk("xor_word", 32'(mem[20'h00200]), 32'h0000_00AA);
        chk("copy_word2", 32'(mem[20'h00042]), 32'h0000_0033);
        chk("wrap_top", 32'(mem[20'hFFFFF]), 32'h0000_00FF);
        chk("wrap_zero", 32'(mem[20'h00000]), 32'h0000_00FF);

        // Reset during the second word's write, then a fresh command.
        rv = '{20'h00C00, 20'h00D00, 16'd4, LFU_XOR, 2, 32'h4433_2211, 32'h0F0F_0F0F};
        wr_cnt = 0;
        load_vec(rv);
        start_cmd(rv, acc);
        for (int k = 0; k < 300; k++) begin
            if (wr_cnt >= 1) break;
            @(posedge clk);
            #1;
        end
        chk("rst_seq_first_write", 32'(wr_cnt), 32'd1);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (MEM_REQ && MEM_WR) break;
        end
        chk("rst_seq_in_write", 32'(MEM_REQ && MEM_WR), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", 32'(MEM_REQ), 32'd0);
        chk("rst_mid_addr", 32'(MEM_ADDR), 32'd0);
        chk("rst_mid_busy", 32'(BUSY), 32'd0);
        chk("rst_mid_ready", 32'(CMD_READY), 32'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_mid_nodone", 32'(DONE), 32'd0);
        end
        sbq.delete();
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post_rst_ready", 32'(CMD_READY), 32'd1);
            chk("post_rst_nodone", 32'(DONE), 32'd0);
            chk("post_rst_noreq", 32'(MEM_REQ), 32'd0);
        end
        run_vec('{20'h00E00, 20'h00F00, 16'd2, 4'b0111, 0, 32'h0000_F00F, 32'h0000_FF0F});
        chk("post_rst_word", 32'(mem[20'h00F01]), 32'h0000_000F);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/blit_lfu_seq.md
BLIT_LFU_SEQ -- requirements
Module: blit_lfu_seq

Interface
REQ-001 Parameter AW, default 20: memory address width in bits.
REQ-002 Parameter DW, default 8: memory data width in bits.
REQ-003 MasterClock  in  1  single clock; all state changes on its rising edge.
REQ-004 RESETL  in  1  reset, asynchronous and active-low.
REQ-005 CMD_VALID  in  1  command offered.
REQ-006 CMD_READY  out  1  command accepted when CMD_VALID and CMD_READY are both high on a rising edge.
REQ-007 CMD_SRC  in  AW  source start address.
REQ-008 CMD_DST  in  AW  destination start address.
REQ-009 CMD_LEN  in  16  transfer length in words; 0 means a null command.
REQ-010 CMD_LFUC  in  4  logic function code.
REQ-011 MEM_REQ  out  1  memory request.
REQ-012 MEM_WR  out  1  1 = write, 0 = read.
REQ-013 MEM_ADDR  out  AW  request address.
REQ-014 MEM_WDATA  out  DW  write data.
REQ-015 MEM_ACK  in  1  request completes on the edge where MEM_ACK is sampled high.
REQ-016 MEM_RDATA  in  DW  read data, valid on the MEM_ACK cycle.
REQ-017 BUSY  out  1  high from command accept until DONE.
REQ-018 DONE  out  1  one-cycle pulse when a command completes.

Function
REQ-019 States: IDLE, RD_SRC, RD_DST, WR_DST, NEXT, FIN.
REQ-020 Only IDLE drives CMD_READY=1.
REQ-021 On accept: latch SRC, DST, LEN and LFUC; go to FIN if LEN==0, else to RD_SRC.
REQ-022 RD_SRC: read MEM_ADDR=src_ptr; on ACK, capture sreg and go to WR_DST if the function is dst-independent, else go to RD_DST.
REQ-023 Dst-independent means LFUC[3]==LFUC[2] and LFUC[1]==LFUC[0]; in that case no destination read is issued.
REQ-024 RD_DST: read MEM_ADDR=dst_ptr; on ACK, capture dreg and go to WR_DST.
REQ-025 WR_DST: write MEM_ADDR=dst_ptr with MEM_WDATA=result; on ACK go to NEXT.
REQ-026 Per bit i, result[i] = LFUC[{sreg[i],dreg[i]}]:
- index 0 = src 0, dst 0
- index 3 = src 1, dst 1
REQ-027 When the dst read is skipped, dreg holds 0; the result is unaffected.
REQ-028 NEXT:
- src_ptr and dst_ptr each increment by 1, modulo 2^AW (wraps to 0 after all-ones)
- remaining decrements
- go to FIN if remaining becomes 0, else to RD_SRC
REQ-029 FIN: DONE=1 for exactly one cycle, then IDLE.
REQ-030 MEM_REQ, MEM_WR, MEM_ADDR and MEM_WDATA are registered.
REQ-031 Those outputs are stable from request assertion until the ACK cycle inclusive.
REQ-032 MEM_REQ is low in the cycle after ACK; there are no back-to-back requests without a gap cycle.
REQ-033 MEM_ACK while MEM_REQ is low is ignored.
REQ-034 MEM_REQ asserts in the first cycle of each RD_SRC, RD_DST and WR_DST state.
REQ-035 Latency per word with zero-wait ACK (ACK in the first REQ cycle): 7 cycles with a dst read, 5 without.
REQ-036 Command inputs are ignored while BUSY; LFUC is not re-sampled mid-command.

Reset
REQ-037 RESETL low asynchronously forces:
- state IDLE
- MEM_REQ=0, MEM_WR=0, MEM_ADDR=0, MEM_WDATA=0
- DONE=0, BUSY=0, CMD_READY=1
- all pointers, counters and data registers 0
REQ-038 A reset mid-transfer abandons the command with no DONE; any outstanding ACK is ignored after release.

Structure
REQ-039 Shared package blit_pkg holds:
- state enum
- LFUC function constants: LFU_ZERO=4'b0000, LFU_SRC=4'b1100, LFU_XOR=4'b0110, LFU_ONE=4'b1111
- LEN width constant 16
REQ-040 One combinational sub-module lfu_word (DW-wide, one 4:1 select per bit) computes the result.

Verification
REQ-041 Accept SRC=0x100, DST=0x200, LEN=1, LFUC=0110; mem[0x100]=0xA5, mem[0x200]=0x0F; zero-wait ACK -> reads 0x100 then 0x200, writes 0x200=0xAA, DONE 7 cycles after the first REQ.
REQ-042 LFUC=1100 (copy), LEN=3, SRC=0x10 holding 0x11,0x22,0x33 -> exactly 3 reads and 3 writes with no dst reads; DST..DST+2 = 0x11,0x22,0x33.
REQ-043 LEN=0 -> no MEM_REQ; DONE pulses 2 cycles after accept; BUSY high for exactly those cycles.
REQ-044 DST=2^AW-1, LEN=2, LFUC=1111 -> writes 0xFF to addr 0xFFFFF, then to addr 0x00000.
REQ-045 ACK delayed 3 cycles on each request -> MEM_ADDR, MEM_WR and MEM_WDATA are unchanged throughout each wait.
REQ-046 RESETL pulsed low during WR_DST of word 2 of LEN=4 -> MEM_REQ falls in the same cycle, no DONE, CMD_READY=1 after release, and a new command runs correctly.
